// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller:
// active-low gfedcba font, scan state encoding and the all-dark segment value.
package seg7_pkg;

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Index is the hex nibble; bit 6 is g, bit 0 is a, 0 = segment lit.
    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-frame write channel: the game logic offers a frame, the scan
// controller accepts it when it has no frame waiting for commit.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [4*NUM_DIGITS-1:0] wr_data;
    logic [NUM_DIGITS-1:0]   wr_blank;
    logic [NUM_DIGITS-1:0]   wr_dp;

    modport master (
        output wr_valid, wr_data, wr_blank, wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_data, wr_blank, wr_dp,
        output wr_ready
    );
endinterface

// File: rtl/seg7_scan_timer.sv
// Slot counter and digit index for the scan; emits single-cycle pulses on
// the last gap cycle, the last cycle of a slot and the last cycle of a frame.
module seg7_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYC    = 500,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             srst,
    output logic             gap_end,
    output logic             slot_end,
    output logic             frame_end,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] idx_nxt
);
    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    // With no gap the pulse lands on cycle 0 so the very first slot after
    // reset still leaves the dark state.
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign gap_end   = (cnt_reg == GAP_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);
    assign idx       = idx_reg;
    assign idx_nxt   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (slot_end) begin
            cnt_reg <= '0;
            idx_reg <= idx_nxt;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with double-buffered
// frame updates. Define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYC    = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_ctrl_if.slave       wr,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] shadow_data_reg, active_data_reg;
    logic [NUM_DIGITS-1:0]   shadow_blank_reg, active_blank_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg, active_dp_reg;
    logic                    pending_reg;
    logic                    ready_reg;
    state_t                  state_reg;
    logic [7:0]              seg_reg;
    logic [NUM_DIGITS-1:0]   an_reg;

    logic             gap_end, slot_end, frame_end;
    logic [IDX_W-1:0] idx, idx_nxt;

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .GAP_CYC    (GAP_CYC),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk       (clk),
        .srst      (rst),
        .gap_end   (gap_end),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .idx       (idx),
        .idx_nxt   (idx_nxt)
    );

    logic xfer, commit;
    assign xfer   = wr.wr_valid && ready_reg;
    assign commit = frame_end && pending_reg;

    logic [NUM_DIGITS-1:0] lzb_mask;
`ifdef SEG7_SCAN_LZB_EN
    logic seen_nz;
    // Scan from the top digit down; everything above the first non-zero
    // nibble goes dark, digit 0 always stays visible.
    always_comb begin
        lzb_mask = '0;
        seen_nz  = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (shadow_data_reg[4*i +: 4] != 4'h0) begin
                seen_nz = 1'b1;
            end
            lzb_mask[i] = !seen_nz;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Values the next lit digit must show: the frame being committed on
    // this edge takes effect immediately.
    logic [4*NUM_DIGITS-1:0] disp_data_next;
    logic [NUM_DIGITS-1:0]   disp_blank_next, disp_dp_next;
    assign disp_data_next  = commit ? shadow_data_reg : active_data_reg;
    assign disp_blank_next = commit ? (shadow_blank_reg | lzb_mask) : active_blank_reg;
    assign disp_dp_next    = commit ? shadow_dp_reg : active_dp_reg;

    logic [IDX_W-1:0]      on_idx;
    logic [3:0]            on_nib;
    logic [7:0]            on_seg;
    logic [NUM_DIGITS-1:0] on_an;

    assign on_idx = slot_end ? idx_nxt : idx;
    assign on_nib = disp_data_next[{on_idx, 2'b00} +: 4];
    assign on_seg = {~disp_dp_next[on_idx], disp_blank_next[on_idx] ? 7'h7F : FONT[on_nib]};

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
            assign on_an[gi] = (on_idx != IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data_reg  <= '0;
            shadow_blank_reg <= '1;
            shadow_dp_reg    <= '0;
            active_data_reg  <= '0;
            active_blank_reg <= '1;
            active_dp_reg    <= '0;
            pending_reg      <= 1'b0;
            ready_reg        <= 1'b1;
            state_reg        <= GAP;
            seg_reg          <= SEG_OFF;
            an_reg           <= '1;
        end else begin
            if (xfer) begin
                shadow_data_reg  <= wr.wr_data;
                shadow_blank_reg <= wr.wr_blank;
                shadow_dp_reg    <= wr.wr_dp;
                pending_reg      <= 1'b1;
                ready_reg        <= 1'b0;
            end else if (commit) begin
                pending_reg      <= 1'b0;
                ready_reg        <= 1'b1;
            end

            if (commit) begin
                active_data_reg  <= disp_data_next;
                active_blank_reg <= disp_blank_next;
                active_dp_reg    <= disp_dp_next;
            end

            case (state_reg)
                GAP: begin
                    if (gap_end) begin
                        state_reg <= ON;
                        seg_reg   <= on_seg;
                        an_reg    <= on_an;
                    end
                end
                ON: begin
                    if (slot_end) begin
                        if (GAP_CYC == 0) begin
                            seg_reg <= on_seg;
                            an_reg  <= on_an;
                        end else begin
                            state_reg <= GAP;
                            seg_reg   <= SEG_OFF;
                            an_reg    <= '1;
                        end
                    end
                end
            endcase
        end
    end

    assign wr.wr_ready = ready_reg;
    assign seg         = seg_reg;
    assign an          = an_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-indexed reference model predicts
// every lit slot and wr_ready; a monitor compares the DUT against it.
module tb_seg7_scan_ctrl;
    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = ND * SD;

    localparam logic [6:0] FONT_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    seg;
    logic [ND-1:0] an;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GAP_CYC    (GC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wr  (bus),
        .seg (seg),
        .an  (an)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state, indexed by cycles since the last reset edge
    int         k = 0;
    bit         live = 1'b0;
    int         rst_count = 0;
    logic       m_pend = 1'b0;
    logic [15:0] m_sh_d = '0, m_ac_d = '0;
    logic [3:0]  m_sh_b = '1, m_sh_p = '0, m_ac_b = '1, m_ac_p = '0;
    logic        exp_ready = 1'b1;
    exp_t        exp_q[$];

    function automatic logic [3:0] lzb_ref(input logic [15:0] d);
        logic [3:0] m = '0;
`ifdef SEG7_SCAN_LZB_EN
        int top = 0;
        for (int i = 0; i < ND; i++) if (d[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < ND; i++) m[i] = (i > top);
`endif
        return m;
    endfunction

    initial begin : model
        bit   commit, xfer;
        int   d;
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                live      = 1'b1;
                rst_count = rst_count + 1;
                k         = 0;
                m_pend    = 1'b0;
                m_ac_d    = '0;
                m_ac_b    = '1;
                m_ac_p    = '0;
            end else if (live) begin
                commit = m_pend && (k % FRAME == FRAME - 1);
                xfer   = bus.wr_valid && !m_pend;
                if (commit) begin
                    m_ac_d = m_sh_d;
                    m_ac_b = m_sh_b | lzb_ref(m_sh_d);
                    m_ac_p = m_sh_p;
                    m_pend = 1'b0;
                end
                if (xfer) begin
                    m_sh_d = bus.wr_data;
                    m_sh_b = bus.wr_blank;
                    m_sh_p = bus.wr_dp;
                    m_pend = 1'b1;
                end
                k = k + 1;
                if (k % SD == GC) begin
                    d     = (k / SD) % ND;
                    e.an  = ~(4'b0001 << d);
                    e.seg = {~m_ac_p[d], m_ac_b[d] ? 7'h7F : FONT_REF[m_ac_d[4*d +: 4]]};
                    exp_q.push_back(e);
                end
            end
            exp_ready = !m_pend;
        end
    end

    initial begin : monitor
        int         seen_rst = 0;
        logic [3:0] prev_an = '1;
        int         gap_run = 0, on_run = 0;
        exp_t       cur;
        bit         have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (!live) continue;
            if (rst_count != seen_rst) begin
                seen_rst = rst_count;
                exp_q.delete();
                prev_an  = '1;
                gap_run  = 0;
                on_run   = 0;
                have_cur = 1'b0;
            end
            check("wr_ready", bus.wr_ready, exp_ready);
            if (an == 4'hF) begin
                check("gap_seg", seg, 8'hFF);
                if (prev_an != 4'hF) begin
                    check("on_len", on_run, SD - GC);
                    gap_run = 0;
                end
                gap_run++;
                on_run = 0;
            end else begin
                if (prev_an == 4'hF) begin
                    check("gap_len", gap_run, GC);
                    check("on_queue", exp_q.size(), 1);
                    have_cur = (exp_q.size() > 0);
                    if (have_cur) cur = exp_q.pop_front();
                    on_run = 0;
                end
                on_run++;
                if (have_cur) begin
                    check("on_an", an, cur.an);
                    check("on_seg", seg, cur.seg);
                end
            end
            prev_an = an;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p, input int hold);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_blank = b;
        bus.wr_dp    = p;
        repeat (hold) @(negedge clk);
        bus.wr_valid = 1'b0;
        $display("write data=%h blank=%b dp=%b hold=%0d", d, b, p, hold);
    endtask

    task automatic wait_ready();
        int g = 0;
        while (bus.wr_ready !== 1'b1 && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", bus.wr_ready, 1'b1);
    endtask

    task automatic wait_phase(input int ph);
        int g = 0;
        while (k % FRAME != ph && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic expect_digit(input int d, input logic [7:0] want);
        logic [3:0] tgt;
        int g = 0;
        tgt = ~(4'b0001 << d);
        while (an !== tgt && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("digit%0d_an", d), an, tgt);
        check($sformatf("digit%0d_seg", d), seg, want);
    endtask

    initial begin : stimulus
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_blank = '0;
        bus.wr_dp    = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_ready", bus.wr_ready, 1'b1);
        rst = 1'b0;

        // Dark scan after reset
        for (int d = 0; d < ND; d++) expect_digit(d, 8'hFF);
        idle(FRAME);

        // Basic decode with one decimal point
        wait_ready();
        write(16'h12AF, 4'b0000, 4'b0100, 1);
        idle(FRAME + 8);
        expect_digit(0, 8'h8E);
        expect_digit(1, 8'h88);
        expect_digit(2, 8'h24);
        expect_digit(3, 8'hF9);

        // Back-to-back: second offer is ignored
        wait_ready();
        wait_phase(3);
        write(16'h3456, 4'b0000, 4'b0000, 1);
        check("b2b_ready_low", bus.wr_ready, 1'b0);
        write(16'h789A, 4'b0000, 4'b0000, 1);
        idle(FRAME + 8);
        expect_digit(0, 8'h82);
        expect_digit(3, 8'hB0);

        // Transfer on the frame-end cycle commits a frame later
        wait_ready();
        wait_phase(FRAME - 1);
        write(16'h4C0D, 4'b0000, 4'b0000, 1);
        check("fe_ready_low", bus.wr_ready, 1'b0);
        expect_digit(0, 8'h82);
        idle(29);
        check("fe_ready_hold", bus.wr_ready, 1'b0);
        idle(2);
        check("fe_ready_rise", bus.wr_ready, 1'b1);
        expect_digit(0, 8'hA1);
        expect_digit(3, 8'h99);

        // Randomized traffic, holds may overlap pending frames
        for (int it = 0; it < 24; it++) begin
            logic [15:0] rd;
            logic [3:0]  rb, rp;
            rd = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rp = 4'($urandom);
            write(rd, rb, rp, $urandom_range(1, 3));
            idle($urandom_range(0, 50));
        end
        idle(2 * FRAME);

`ifdef SEG7_SCAN_LZB_EN
        wait_ready();
        write(16'h0050, 4'b0000, 4'b0000, 1);
        idle(FRAME + 8);
        expect_digit(3, 8'hFF);
        expect_digit(2, 8'hFF);
        expect_digit(1, 8'h92);
        expect_digit(0, 8'hC0);
        wait_ready();
        write(16'h0000, 4'b0000, 4'b0000, 1);
        idle(FRAME + 8);
        expect_digit(0, 8'hC0);
        expect_digit(1, 8'hFF);
        expect_digit(3, 8'hFF);
`else
        wait_ready();
        write(16'h0050, 4'b0000, 4'b0000, 1);
        idle(FRAME + 8);
        expect_digit(3, 8'hC0);
        expect_digit(1, 8'h92);
`endif

        // Reset during digit 2 with a frame pending drops the frame
        wait_ready();
        wait_phase(4);
        write(16'h8888, 4'b0000, 4'b1111, 1);
        wait_phase(20);
        check("pre_rst_an", an, 4'b1011);
        check("pre_rst_ready", bus.wr_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_seg", seg, 8'hFF);
        check("mid_rst_ready", bus.wr_ready, 1'b1);
        rst = 1'b0;
        for (int d = 0; d < ND; d++) expect_digit(d, 8'hFF);
        idle(2 * FRAME);
        for (int d = 0; d < ND; d++) expect_digit(d, 8'hFF);

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment digits. It shares one hex-to-segment decode path across NUM_DIGITS digits, driving one digit at a time with a guard gap to prevent ghosting. New display values (score, timer) are written through a valid/ready handshake and double-buffered, so updates take effect only at frame boundaries and never tear. It sits between the game logic and the board segment/anode pins.

## Interface
- NUM_DIGITS, 4: number of scanned digits, 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must satisfy SCAN_DIV > GAP_CYC + 1.
- GAP_CYC, 500: cycles at the start of each slot with all anodes off; may be 0.
- clk  in  1  single system clock.
- rst  in  1  reset, synchronous and active-high.
- wr_valid  in  1  new display frame offered.
- wr_ready  out  1  controller can accept a frame.
- wr_data  in  4*NUM_DIGITS  hex nibbles; digit i is [4i+3:4i], digit 0 is rightmost.
- wr_blank  in  NUM_DIGITS  per-digit force-blank, 1 = dark.
- wr_dp  in  NUM_DIGITS  per-digit decimal point, 1 = lit.
- seg  out  8  active-low segments, {dp,g,f,e,d,c,b,a}.
- an  out  NUM_DIGITS  active-low digit enables.

## Operation
- Registers: shadow {data, blank, dp}, active {data, blank, dp}, pending flag, slot counter, digit index, and state.
- Handshake: transfer occurs when wr_valid && wr_ready. The transfer loads the shadow registers and sets pending. wr_ready = !pending.
- Commit: on the last cycle of the last digit's slot, if pending, copy shadow to active and clear pending.
- States: GAP (an all 1, seg 8'hFF) -> ON (an bit idx = 0, others 1) -> GAP of the next digit. If GAP_CYC = 0, GAP is skipped.
- Digit index increments 0 .. NUM_DIGITS-1 and wraps to 0.
- Font is active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- A blanked digit drives seg[6:0] = 7'h7F. The dp bit is independent: seg[7] = ~dp[idx].

## Timing
- All outputs are registered.
- Reset values:
  - an all 1, seg 8'hFF, wr_ready 1.
  - Active data 0, active blank all 1 (display dark until the first write).
  - Index 0, counter 0, state GAP.
- Slot length is exactly SCAN_DIV cycles: GAP_CYC in GAP, then SCAN_DIV-GAP_CYC in ON.
- Frame length is NUM_DIGITS*SCAN_DIV cycles.
- wr_ready falls the cycle after a transfer and rises the cycle after the commit.
- Worst-case accept-to-display latency is one frame plus one slot.
- A transfer in the same cycle as a frame boundary commits at the next boundary. The currently held shadow, if any, commits now. A transfer cannot occur while pending, because wr_ready = 0.
- wr_valid while wr_ready = 0 is ignored; the data is not captured.
- rst asserted mid-frame returns all state to reset values on the next edge. Any pending frame is dropped.

## Configuration
- SEG7_SCAN_LZB_EN: when defined, leading-zero blanking applies on commit. Digits from NUM_DIGITS-1 down, whose nibble is 0 and which are higher than the highest non-zero digit, are blanked. Digit 0 is never blanked by this rule. Explicit wr_blank still ORs in.
- When SEG7_SCAN_LZB_EN is undefined, only wr_blank controls blanking.

## Structure
- Package seg7_pkg holds:
  - The 16-entry font constant array.
  - The state typedef (GAP, ON).
  - SEG_OFF = 8'hFF.
- One sub-module, seg7_scan_timer: owns the slot counter and emits gap_end, slot_end and frame_end pulses.
- The font lookup stays inline in seg7_scan_ctrl.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, GAP_CYC=2.
- Reset, then no writes -> an = 4'b1111 for 2 cycles, then walks 1110, 1101, 1011, 0111 with 6 cycles each. seg = 8'hFF throughout because all digits are blanked.
- Write data=16'h12AF, blank=0, dp=4'b0100 -> after commit, digit0 seg = 8'h8E, digit1 = 8'h88, digit2 = 8'h24 (dp lit), digit3 = 8'hF9.
- Two writes back-to-back -> second wr_valid sees wr_ready = 0 and is not captured. The first frame appears on the next frame's slot 0.
- Write landing on the frame_end cycle -> the previous shadow commits. The new value appears one full frame later, and wr_ready stays 0 until that commit.
- With SEG7_SCAN_LZB_EN, write 16'h0050 -> digits 3 and 2 dark, digit1 = 8'h92, digit0 = 8'hC0. Write 16'h0000 -> only digit0 lit, showing 8'hC0.
- rst pulsed during digit 2 ON with a frame pending -> next cycle an = 4'b1111, seg = 8'hFF, wr_ready = 1, and the pending frame is never displayed.
